// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared definitions for the command controller: widths, opcodes, operand
// addresses and the state encodings of the controller and TX handshake.
package sys_cmd_ctrl_pkg;

  localparam int DATA_WD    = 8;
  localparam int ADDR_WD    = 4;
  localparam int ALU_FUN_WD = 4;

  localparam logic [DATA_WD-1:0] CMD_WR      = 8'hAA;
  localparam logic [DATA_WD-1:0] CMD_RD      = 8'hBB;
  localparam logic [DATA_WD-1:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [DATA_WD-1:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [ADDR_WD-1:0] OPA_ADDR = ADDR_WD'(0);
  localparam logic [ADDR_WD-1:0] OPB_ADDR = ADDR_WD'(1);

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OPA,
    OPB,
    ALU_FUN_ST,
    ALU_WAIT,
    TX_LO,
    TX_HI
  } ctrl_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_WAIT_FREE,
    HS_REQ,
    HS_RELEASE
  } tx_hs_state_e;

endpackage

// File: rtl/sys_cmd_ctrl_tx.sv
// Per-byte request/acknowledge/release handshake towards the UART transmitter.
// A start pulse loads the byte; done pulses once the UART has taken it and
// gone idle again, so the caller can chain the next byte straight away.
module tx_byte_handshake
  import sys_cmd_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [DATA_WD-1:0] data_i,
  input  logic               txBusy_i,
  output logic [DATA_WD-1:0] txData_o,
  output logic               txVld_o,
  output logic               done_o
);

  tx_hs_state_e       stateQ, stateD;
  logic [DATA_WD-1:0] dataQ, dataD;
  logic               vldQ, vldD;

  // State, held byte and request flag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateQ <= HS_IDLE;
      dataQ  <= '0;
      vldQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      dataQ  <= dataD;
      vldQ   <= vldD;
    end
  end

  // Wait for a free UART, raise the request until busy is seen, then wait for release.
  always_comb begin
    stateD = stateQ;
    dataD  = dataQ;
    vldD   = vldQ;
    done_o = 1'b0;
    case (stateQ)
      HS_IDLE: begin
        if (start_i) begin
          dataD  = data_i;
          stateD = HS_WAIT_FREE;
        end
      end
      HS_WAIT_FREE: begin
        if (!txBusy_i) begin
          vldD   = 1'b1;
          stateD = HS_REQ;
        end
      end
      HS_REQ: begin
        if (txBusy_i) begin
          vldD   = 1'b0;
          stateD = HS_RELEASE;
        end
      end
      HS_RELEASE: begin
        if (!txBusy_i) begin
          done_o = 1'b1;
          stateD = HS_IDLE;
        end
      end
      default: stateD = HS_IDLE;
    endcase
  end

  assign txData_o = dataQ;
  assign txVld_o  = vldQ;

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command-level controller: parses framed UART bytes, drives register-file
// writes/reads and ALU operations, gates the ALU clock and returns results
// through the UART TX handshake one byte at a time.
module sys_cmd_ctrl
  import sys_cmd_ctrl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WD-1:0]    RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WD-1:0]    RF_RD_DATA,
  input  logic                  RF_RD_VLD,
  input  logic [2*DATA_WD-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  TX_BUSY,
  output logic [ADDR_WD-1:0]    RF_ADDR,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [DATA_WD-1:0]    RF_WR_DATA,
  output logic                  ALU_EN,
  output logic [ALU_FUN_WD-1:0] ALU_FUN,
  output logic                  CLKG_EN,
  output logic [DATA_WD-1:0]    TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);

  ctrl_state_e           stateQ, stateD;
  logic [ADDR_WD-1:0]    rfAddrQ, rfAddrD;
  logic [DATA_WD-1:0]    rfWrDataQ, rfWrDataD;
  logic                  rfWrEnQ, rfWrEnD;
  logic                  rfRdEnQ, rfRdEnD;
  logic                  aluEnQ, aluEnD;
  logic [ALU_FUN_WD-1:0] aluFunQ, aluFunD;
  logic                  clkgEnQ, clkgEnD;
  logic                  cmdErrQ, cmdErrD;
  logic [2*DATA_WD-1:0]  resultQ, resultD;
  logic                  hasHiQ, hasHiD;
  logic                  txStartQ, txStartD;
  logic [DATA_WD-1:0]    txByte;
  logic                  txDone;

  // All controller state and registered outputs; reset aborts any command in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stateQ    <= IDLE;
      rfAddrQ   <= '0;
      rfWrDataQ <= '0;
      rfWrEnQ   <= 1'b0;
      rfRdEnQ   <= 1'b0;
      aluEnQ    <= 1'b0;
      aluFunQ   <= '0;
      clkgEnQ   <= 1'b0;
      cmdErrQ   <= 1'b0;
      resultQ   <= '0;
      hasHiQ    <= 1'b0;
      txStartQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      rfAddrQ   <= rfAddrD;
      rfWrDataQ <= rfWrDataD;
      rfWrEnQ   <= rfWrEnD;
      rfRdEnQ   <= rfRdEnD;
      aluEnQ    <= aluEnD;
      aluFunQ   <= aluFunD;
      clkgEnQ   <= clkgEnD;
      cmdErrQ   <= cmdErrD;
      resultQ   <= resultD;
      hasHiQ    <= hasHiD;
      txStartQ  <= txStartD;
    end
  end

  // Command sequencing: strobes default low, held fields keep their value.
  always_comb begin
    stateD    = stateQ;
    rfAddrD   = rfAddrQ;
    rfWrDataD = rfWrDataQ;
    rfWrEnD   = 1'b0;
    rfRdEnD   = 1'b0;
    aluEnD    = 1'b0;
    aluFunD   = aluFunQ;
    cmdErrD   = 1'b0;
    resultD   = resultQ;
    hasHiD    = hasHiQ;
    txStartD  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:      stateD = WR_ADDR;
            CMD_RD:      stateD = RD_ADDR;
            CMD_ALU_OP:  stateD = OPA;
            CMD_ALU_NOP: stateD = ALU_FUN_ST;
            default:     cmdErrD = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          rfAddrD = RX_P_DATA[ADDR_WD-1:0];
          stateD  = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          rfWrDataD = RX_P_DATA;
          rfWrEnD   = 1'b1;
          stateD    = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          rfAddrD = RX_P_DATA[ADDR_WD-1:0];
          rfRdEnD = 1'b1;
          stateD  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RF_RD_VLD) begin
          resultD  = {{DATA_WD{1'b0}}, RF_RD_DATA};
          hasHiD   = 1'b0;
          txStartD = 1'b1;
          stateD   = TX_LO;
        end
      end
      OPA: begin
        if (RX_D_VLD) begin
          rfAddrD   = OPA_ADDR;
          rfWrDataD = RX_P_DATA;
          rfWrEnD   = 1'b1;
          stateD    = OPB;
        end
      end
      OPB: begin
        if (RX_D_VLD) begin
          rfAddrD   = OPB_ADDR;
          rfWrDataD = RX_P_DATA;
          rfWrEnD   = 1'b1;
          stateD    = ALU_FUN_ST;
        end
      end
      ALU_FUN_ST: begin
        if (RX_D_VLD) begin
          aluFunD = RX_P_DATA[ALU_FUN_WD-1:0];
          aluEnD  = 1'b1;
          stateD  = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          resultD  = ALU_OUT;
          hasHiD   = 1'b1;
          txStartD = 1'b1;
          stateD   = TX_LO;
        end
      end
      TX_LO: begin
        if (txDone) begin
          if (hasHiQ) begin
            txStartD = 1'b1;
            stateD   = TX_HI;
          end else begin
            stateD = IDLE;
          end
        end
      end
      TX_HI: begin
        if (txDone) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
    clkgEnD = (stateD == ALU_FUN_ST) || (stateD == ALU_WAIT);
  end

  assign txByte = (stateQ == TX_HI) ? resultQ[2*DATA_WD-1:DATA_WD] : resultQ[DATA_WD-1:0];

  tx_byte_handshake uTxHs (
    .clk_i    (CLK),
    .rst_i    (RST),
    .start_i  (txStartQ),
    .data_i   (txByte),
    .txBusy_i (TX_BUSY),
    .txData_o (TX_P_DATA),
    .txVld_o  (TX_D_VLD),
    .done_o   (txDone)
  );

  assign RF_ADDR    = rfAddrQ;
  assign RF_WR_EN   = rfWrEnQ;
  assign RF_RD_EN   = rfRdEnQ;
  assign RF_WR_DATA = rfWrDataQ;
  assign ALU_EN     = aluEnQ;
  assign ALU_FUN    = aluFunQ;
  assign CLKG_EN    = clkgEnQ;
  assign CMD_ERR    = cmdErrQ;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: host-side command model, RF/ALU/UART responders and
// a per-cycle monitor comparing observed transactions against the model.
module tb_sys_cmd_ctrl;
  import sys_cmd_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RF_RD_DATA = 8'h00;
  logic        RF_RD_VLD = 1'b0;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        ALU_OUT_VLD = 1'b0;
  logic        TX_BUSY = 1'b0;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN;
  logic        RF_RD_EN;
  logic [7:0]  RF_WR_DATA;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLKG_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        CMD_ERR;

  sys_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .TX_BUSY(TX_BUSY), .RF_ADDR(RF_ADDR),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_WR_DATA(RF_WR_DATA),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLKG_EN(CLKG_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
  );

  // Free-running system clock.
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;

  // Expected transactions, appended by the host model only.
  wr_t        expWr[$];
  logic [3:0] expRd[$];
  logic [3:0] expAlu[$];
  logic [7:0] expTx[$];
  int         expErrCnt = 0;
  logic [7:0] modelMem [16];

  // Monitor-side progress and environment state.
  int         wrIdx = 0, rdIdx = 0, aluIdx = 0, txIdx = 0, seenErrCnt = 0;
  logic [7:0] rfMem [16] = '{default: 8'h00};
  logic [7:0] txLog[$];
  int         cycleNo = 0;
  int         forceUntil = 0;
  bit         busyDriven = 1'b0;
  int         uartBusyLeft = 0;
  bit         rdPending = 1'b0;
  logic [3:0] rdAddr = 4'h0;
  int         aluLeft = 0;
  logic [15:0] aluRes = 16'h0000;
  bit         aluInFlight = 1'b0;
  bit         prevVld = 1'b0;
  bit         prevErr = 1'b0;

  function automatic logic [15:0] aluFn(input logic [3:0] fun, input logic [7:0] a,
                                        input logic [7:0] b);
    case (fun)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      default: return {8'h00, a & b};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Environment (RF, ALU, UART) plus transaction checks, sampled on the falling edge.
  always @(negedge CLK) begin
    cycleNo++;
    if (aluInFlight) checkOutput("clkg_while_alu_busy", CLKG_EN, 1);
    if (TX_D_VLD) checkOutput("clkg_off_during_tx", CLKG_EN, 0);

    if (RF_WR_EN) begin
      checkOutput("rf_write_expected", wrIdx < expWr.size(), 1);
      if (wrIdx < expWr.size()) begin
        checkOutput("rf_wr_addr", RF_ADDR, expWr[wrIdx].addr);
        checkOutput("rf_wr_data", RF_WR_DATA, expWr[wrIdx].data);
        wrIdx++;
      end
      rfMem[RF_ADDR] = RF_WR_DATA;
    end

    if (rdPending) begin
      RF_RD_VLD  = 1'b1;
      RF_RD_DATA = rfMem[rdAddr];
      rdPending  = 1'b0;
    end else begin
      RF_RD_VLD = 1'b0;
    end
    if (RF_RD_EN) begin
      checkOutput("rf_read_expected", rdIdx < expRd.size(), 1);
      if (rdIdx < expRd.size()) begin
        checkOutput("rf_rd_addr", RF_ADDR, expRd[rdIdx]);
        rdIdx++;
      end
      rdPending = 1'b1;
      rdAddr    = RF_ADDR;
    end

    ALU_OUT_VLD = 1'b0;
    if (aluLeft > 0) begin
      aluLeft--;
      if (aluLeft == 0) begin
        ALU_OUT     = aluRes;
        ALU_OUT_VLD = 1'b1;
        aluInFlight = 1'b0;
      end
    end
    if (ALU_EN) begin
      checkOutput("alu_op_expected", aluIdx < expAlu.size(), 1);
      if (aluIdx < expAlu.size()) begin
        checkOutput("alu_fun", ALU_FUN, expAlu[aluIdx]);
        aluIdx++;
      end
      checkOutput("clkg_at_alu_en", CLKG_EN, 1);
      aluRes      = aluFn(ALU_FUN, rfMem[0], rfMem[1]);
      aluLeft     = 3;
      aluInFlight = 1'b1;
    end

    if (CMD_ERR) begin
      checkOutput("cmd_err_expected", seenErrCnt < expErrCnt, 1);
      checkOutput("cmd_err_one_cycle", prevErr, 0);
      seenErrCnt++;
    end
    prevErr = CMD_ERR;

    if (TX_D_VLD && !prevVld) checkOutput("tx_req_only_when_free", busyDriven, 0);
    if (TX_D_VLD && !busyDriven) begin
      txLog.push_back(TX_P_DATA);
      checkOutput("tx_byte_expected", txIdx < expTx.size(), 1);
      if (txIdx < expTx.size()) begin
        checkOutput("tx_byte", TX_P_DATA, expTx[txIdx]);
        txIdx++;
      end
      uartBusyLeft = 4;
    end
    prevVld    = TX_D_VLD;
    busyDriven = (uartBusyLeft > 0) || (cycleNo < forceUntil);
    if (uartBusyLeft > 0) uartBusyLeft--;
    TX_BUSY = busyDriven;
  end

  task automatic sendByte(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    @(negedge CLK);
  endtask

  // Host-level meaning of a command, then delivery and a bounded wait for completion.
  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input int n, input int busyHold);
    logic [15:0] r;
    bit done;
    case (b0)
      8'hAA: begin
        modelMem[b1[3:0]] = b2;
        expWr.push_back(wr_t'({b1[3:0], b2}));
      end
      8'hBB: begin
        expRd.push_back(b1[3:0]);
        expTx.push_back(modelMem[b1[3:0]]);
      end
      8'hCC: begin
        modelMem[0] = b1;
        modelMem[1] = b2;
        expWr.push_back(wr_t'({4'h0, b1}));
        expWr.push_back(wr_t'({4'h1, b2}));
        r = aluFn(b3[3:0], b1, b2);
        expAlu.push_back(b3[3:0]);
        expTx.push_back(r[7:0]);
        expTx.push_back(r[15:8]);
      end
      8'hDD: begin
        r = aluFn(b1[3:0], modelMem[0], modelMem[1]);
        expAlu.push_back(b1[3:0]);
        expTx.push_back(r[7:0]);
        expTx.push_back(r[15:8]);
      end
      default: expErrCnt++;
    endcase
    sendByte(b0);
    if (n > 1) sendByte(b1);
    if (n > 2) sendByte(b2);
    if (busyHold > 0) forceUntil = cycleNo + busyHold;
    if (n > 3) sendByte(b3);
    if (busyHold > 0) begin
      sendByte(8'h55);
      sendByte(8'hBB);
      checkOutput("no_tx_while_forced_busy", TX_D_VLD, 0);
    end
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      done = (wrIdx == expWr.size()) && (rdIdx == expRd.size()) &&
             (aluIdx == expAlu.size()) && (txIdx == expTx.size()) &&
             (seenErrCnt == expErrCnt) && !busyDriven && (cycleNo >= forceUntil) &&
             !aluInFlight && !rdPending;
      if (done) break;
      @(negedge CLK);
    end
    checkOutput("command_completes", done, 1);
    repeat (3) @(negedge CLK);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rf_addr"}, RF_ADDR, 0);
    checkOutput({tag, "_rf_wr_en"}, RF_WR_EN, 0);
    checkOutput({tag, "_rf_rd_en"}, RF_RD_EN, 0);
    checkOutput({tag, "_rf_wr_data"}, RF_WR_DATA, 0);
    checkOutput({tag, "_alu_en"}, ALU_EN, 0);
    checkOutput({tag, "_alu_fun"}, ALU_FUN, 0);
    checkOutput({tag, "_clkg_en"}, CLKG_EN, 0);
    checkOutput({tag, "_tx_data"}, TX_P_DATA, 0);
    checkOutput({tag, "_tx_vld"}, TX_D_VLD, 0);
    checkOutput({tag, "_cmd_err"}, CMD_ERR, 0);
  endtask

  // Directed command sequence with literal anchors on the model.
  initial begin
    int base;
    RST       = 1'b1;
    RX_P_DATA = 8'h00;
    RX_D_VLD  = 1'b0;
    for (int i = 0; i < 16; i++) modelMem[i] = 8'h00;
    repeat (2) @(negedge CLK);
    checkAllZero("reset");
    RST = 1'b0;

    $display("[TB] write then read");
    applyStimulus(8'hAA, 8'h05, 8'h3C, 8'h00, 3, 0);
    checkOutput("lit_wr_addr", RF_ADDR, 4'h5);
    checkOutput("lit_wr_data", RF_WR_DATA, 8'h3C);
    base = txLog.size();
    applyStimulus(8'hBB, 8'h05, 8'h00, 8'h00, 2, 0);
    checkOutput("lit_rd_tx_count", txLog.size() - base, 1);
    if (txLog.size() > base) checkOutput("lit_rd_tx", txLog[base], 8'h3C);

    $display("[TB] alu with operands");
    base = txLog.size();
    applyStimulus(8'hCC, 8'h0A, 8'h03, 8'h02, 4, 0);
    checkOutput("lit_alu_fun_mul", ALU_FUN, 4'h2);
    checkOutput("lit_rf0", rfMem[0], 8'h0A);
    checkOutput("lit_rf1", rfMem[1], 8'h03);
    checkOutput("lit_alu_tx_count", txLog.size() - base, 2);
    if (txLog.size() > base + 1) begin
      checkOutput("lit_alu_tx_lo", txLog[base], 8'h1E);
      checkOutput("lit_alu_tx_hi", txLog[base+1], 8'h00);
    end
    checkOutput("lit_clkg_idle", CLKG_EN, 0);

    $display("[TB] alu on stored operands");
    base = txLog.size();
    applyStimulus(8'hDD, 8'h01, 8'h00, 8'h00, 2, 0);
    checkOutput("lit_alu_fun_sub", ALU_FUN, 4'h1);
    checkOutput("lit_nop_tx_count", txLog.size() - base, 2);
    if (txLog.size() > base + 1) begin
      checkOutput("lit_nop_tx_lo", txLog[base], 8'h07);
      checkOutput("lit_nop_tx_hi", txLog[base+1], 8'h00);
    end

    $display("[TB] bad opcode then write");
    applyStimulus(8'h55, 8'h00, 8'h00, 8'h00, 1, 0);
    checkOutput("lit_err_seen", seenErrCnt, 1);
    applyStimulus(8'hAA, 8'h02, 8'h11, 8'h00, 3, 0);
    checkOutput("lit_rf2", rfMem[2], 8'h11);

    $display("[TB] address truncation");
    applyStimulus(8'hAA, 8'h13, 8'h5A, 8'h00, 3, 0);
    checkOutput("lit_rf3", rfMem[3], 8'h5A);
    base = txLog.size();
    applyStimulus(8'hBB, 8'hF3, 8'h00, 8'h00, 2, 0);
    checkOutput("lit_trunc_rd_addr", RF_ADDR, 4'h3);
    if (txLog.size() > base) checkOutput("lit_trunc_tx", txLog[base], 8'h5A);

    $display("[TB] tx backpressure with ignored rx");
    base = txLog.size();
    applyStimulus(8'hDD, 8'h02, 8'h00, 8'h00, 2, 20);
    checkOutput("lit_bp_tx_count", txLog.size() - base, 2);
    if (txLog.size() > base + 1) begin
      checkOutput("lit_bp_tx_lo", txLog[base], 8'h1E);
      checkOutput("lit_bp_tx_hi", txLog[base+1], 8'h00);
    end

    $display("[TB] reset mid-command");
    sendByte(8'hAA);
    sendByte(8'h07);
    RST = 1'b1;
    @(negedge CLK);
    checkAllZero("midreset");
    RST = 1'b0;
    applyStimulus(8'h99, 8'h00, 8'h00, 8'h00, 1, 0);
    checkOutput("lit_err_after_reset", seenErrCnt, 2);

    checkOutput("all_writes_seen", wrIdx, expWr.size());
    checkOutput("all_tx_seen", txIdx, expTx.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
Command-level system controller between the UART byte interface and the register-file/ALU datapath. It parses framed command bytes from UART RX and sequences register-file reads/writes and ALU operations. It gates the ALU clock and streams results back through UART TX with a busy handshake. It replaces per-operation sweeping with host-driven, one-command-at-a-time execution.

Parameters:
DATA_WD, 8, byte width of UART/RF data
ADDR_WD, 4, register-file address width
ALU_FUN_WD, 4, ALU function code width
CMD_WR, 8'hAA, opcode: RF write (addr, data)
CMD_RD, 8'hBB, opcode: RF read (addr)
CMD_ALU_OP, 8'hCC, opcode: ALU with operands (A, B, fun)
CMD_ALU_NOP, 8'hDD, opcode: ALU on stored operands (fun)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
RX_P_DATA  in  DATA_WD  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
RF_RD_DATA  in  DATA_WD  RF read data
RF_RD_VLD  in  1  RF read data valid (1 cycle after RF_RD_EN)
ALU_OUT  in  2*DATA_WD  ALU result
ALU_OUT_VLD  in  1  ALU result valid
TX_BUSY  in  1  UART TX serialising
RF_ADDR  out  ADDR_WD  RF address
RF_WR_EN  out  1  RF write strobe
RF_RD_EN  out  1  RF read strobe
RF_WR_DATA  out  DATA_WD  RF write data
ALU_EN  out  1  ALU operation strobe
ALU_FUN  out  ALU_FUN_WD  ALU function code
CLKG_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  DATA_WD  byte to transmit
TX_D_VLD  out  1  TX request
CMD_ERR  out  1  one-cycle pulse, unknown opcode

Behaviour:
- Reset is synchronous, active-high: state IDLE; all outputs 0; held registers cleared. RST mid-command aborts it immediately; no partial RF write completes after the reset cycle.
- RF_WR_EN, RF_RD_EN, ALU_EN, and CMD_ERR are one-cycle registered pulses. RF_ADDR, RF_WR_DATA, ALU_FUN, and TX_P_DATA hold their value until they are next updated.
- IDLE: on RX_D_VLD, decode the byte:
  - AA -> WR_ADDR
  - BB -> RD_ADDR
  - CC -> OPA
  - DD -> ALU_FUN_ST
  - other -> pulse CMD_ERR, stay in IDLE
- WR_ADDR: next RX byte[ADDR_WD-1:0] is latched to RF_ADDR -> WR_DATA.
- WR_DATA: next RX byte drives RF_WR_DATA and pulses RF_WR_EN the following cycle -> IDLE. No TX response.
- RD_ADDR: next RX byte sets RF_ADDR and pulses RF_RD_EN -> RD_WAIT.
- RD_WAIT: on RF_RD_VLD, latch the data into a single-byte TX buffer -> TX_LO.
- OPA: RX byte is written to RF address 0 (RF_WR_EN pulse) -> OPB.
- OPB: RX byte is written to RF address 1 -> ALU_FUN_ST.
- ALU_FUN_ST: on the RX byte:
  - CLKG_EN=1.
  - ALU_FUN=byte[ALU_FUN_WD-1:0].
  - Pulse ALU_EN the next cycle -> ALU_WAIT.
- ALU_WAIT: CLKG_EN=1. On ALU_OUT_VLD, latch the 16-bit result and drop CLKG_EN the following cycle -> TX_LO (low byte first, then TX_HI).
- CLKG_EN is 1 only in ALU_FUN_ST and ALU_WAIT; it is 0 otherwise.
- TX handshake, per byte:
  - Assert TX_D_VLD with TX_P_DATA once TX_BUSY=0.
  - Hold TX_D_VLD until TX_BUSY is seen 1, then deassert.
  - Wait for TX_BUSY=0 before the next byte or before returning to IDLE.
  - TX_LO of a read -> IDLE. TX_LO of an ALU result -> TX_HI -> IDLE.
- RX_D_VLD is ignored in RD_WAIT, ALU_WAIT, TX_LO, and TX_HI; no buffering, and the host must wait for the response.
- RX_D_VLD in the same cycle as RF_RD_VLD or ALU_OUT_VLD: the VLD input wins and the RX byte is dropped.
- Address bytes wider than ADDR_WD are truncated; RF_ADDR wraps modulo 2^ADDR_WD.
- Latency:
  - AA: the final RX strobe is followed by RF_WR_EN 1 cycle later.
  - CC/DD: the fun byte is followed by ALU_EN 1 cycle later.

Decomposition:
- Shared package holds:
  - the opcode constants CMD_WR/RD/ALU_OP/ALU_NOP;
  - the operand addresses OPA_ADDR=0 and OPB_ADDR=1;
  - the state encoding enum (IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, ALU_FUN_ST, ALU_WAIT, TX_LO, TX_HI).
- One natural sub-module, tx_byte_handshake: the per-byte TX_D_VLD/TX_BUSY request-ack-release FSM with start and done signals, reused for both bytes.

Test Plan:
- Write then read: RX AA,05,3C then BB,05; RF returns 3C -> RF_WR_EN with RF_ADDR=5, RF_WR_DATA=3C; RF_RD_EN with RF_ADDR=5; TX byte 3C.
- ALU with operands: RX CC,0A,03,02; ALU_OUT=001E -> RF writes addr0=0A and addr1=03; ALU_EN with ALU_FUN=2; CLKG_EN high until the result; TX 1E then 00.
- ALU on stored operands: RX DD,01; ALU_OUT=0007 -> no RF write; ALU_EN with FUN=1; TX 07, 00.
- Bad opcode: RX 55 -> one-cycle CMD_ERR; state stays IDLE; next AA command executes normally.
- TX backpressure: TX_BUSY held 1 for 20 cycles when a response is ready -> TX_D_VLD is not asserted until busy=0; exactly two bytes are sent; RX bytes during TX are ignored.
- Reset mid-command: RX AA,07, then RST for 1 cycle, then byte 99 -> no RF_WR_EN; all outputs 0; byte 99 raises CMD_ERR.
